// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton conditioner bank: repeat FSM states
// and default cycle counts for a 25 MHz clock.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      HELD_DELAY  = 2'd1,
      HELD_REPEAT = 2'd2
   } state_t;

   localparam int DEF_SYNC_STAGES  = 2;
   localparam int DEF_DEBOUNCE_CYC = 50000;     // 2 ms
   localparam int DEF_REPEAT_DELAY = 12500000;  // 0.5 s
   localparam int DEF_REPEAT_RATE  = 2500000;   // 0.1 s

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: synchroniser, debounce counter and typematic repeat FSM.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | button released (debounced level low)
// HELD_DELAY  | held; waiting REPEAT_DELAY enabled cycles for first repeat
// HELD_REPEAT | held and repeating; press every REPEAT_RATE cycles
module btn_chan
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   input  logic repeat_en,
   output logic level,
   output logic press,
   output logic release_pulse
);

   localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
   localparam int TM_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [TM_W-1:0] DELAY_LD = TM_W'(REPEAT_DELAY - 1);
   localparam logic [TM_W-1:0] RATE_LD  = TM_W'(REPEAT_RATE - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [DB_W-1:0]        db_cnt;
   logic [TM_W-1:0]        tmr, tmr_nxt;
   state_t                 state, state_nxt;
   logic                   press_nxt, rel_nxt;
   logic                   btn_s, db_flip, lvl_rise, lvl_fall;

   assign btn_s    = sync_q[SYNC_STAGES-1];
   // Level toggles on the DEBOUNCE_CYC-th consecutive mismatching cycle; the
   // FSM reacts to that same edge so level and press/release stay aligned.
   assign db_flip  = (btn_s != level) && (db_cnt == DB_LAST);
   assign lvl_rise = db_flip & ~level;
   assign lvl_fall = db_flip & level;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q        <= '0;
         db_cnt        <= '0;
         level         <= 1'b0;
         state         <= IDLE;
         tmr           <= '0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
         if (btn_s == level) begin
            db_cnt <= '0;
         end else if (db_flip) begin
            db_cnt <= '0;
            level  <= ~level;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
         state         <= state_nxt;
         tmr           <= tmr_nxt;
         press         <= press_nxt;
         release_pulse <= rel_nxt;
      end
   end

   // Repeat timer is a down-counter: loaded with interval-1, fires at zero.
   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      press_nxt = 1'b0;
      rel_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (lvl_rise) begin
               state_nxt = HELD_DELAY;
               tmr_nxt   = DELAY_LD;
               press_nxt = 1'b1;
            end
         end
         HELD_DELAY: begin
            if (lvl_fall) begin
               state_nxt = IDLE;
               rel_nxt   = 1'b1;
            end else if (!repeat_en) begin
               tmr_nxt = DELAY_LD;
            end else if (tmr == '0) begin
               state_nxt = HELD_REPEAT;
               tmr_nxt   = RATE_LD;
               press_nxt = 1'b1;
            end else begin
               tmr_nxt = tmr - TM_W'(1);
            end
         end
         HELD_REPEAT: begin
            if (lvl_fall) begin
               state_nxt = IDLE;
               rel_nxt   = 1'b1;
            end else if (!repeat_en) begin
               state_nxt = HELD_DELAY;
               tmr_nxt   = DELAY_LD;
            end else if (tmr == '0) begin
               tmr_nxt   = RATE_LD;
               press_nxt = 1'b1;
            end else begin
               tmr_nxt = tmr - TM_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            tmr_nxt   = '0;
         end
      endcase
   end

endmodule

// File: rtl/btn_debounce_bank.sv
// Bank of independent pushbutton conditioners; wiring plus parameter
// legality checks.
module btn_debounce_bank
   import btn_pkg::*;
#(
   parameter int N_CH         = 4,
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_in,
   input  logic [N_CH-1:0] repeat_en,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] press,
   output logic [N_CH-1:0] release_pulse
);

   if (N_CH < 1)         begin : g_bad_nch   $error("N_CH must be at least 1");         end
   if (SYNC_STAGES < 2)  begin : g_bad_sync  $error("SYNC_STAGES must be at least 2");  end
   if (DEBOUNCE_CYC < 1) begin : g_bad_db    $error("DEBOUNCE_CYC must be at least 1"); end
   if (REPEAT_DELAY < 1) begin : g_bad_delay $error("REPEAT_DELAY must be at least 1"); end
   if (REPEAT_RATE < 1)  begin : g_bad_rate  $error("REPEAT_RATE must be at least 1");  end

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      btn_chan #(
         .SYNC_STAGES  (SYNC_STAGES),
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
      ) u_chan (
         .clk           (clk),
         .rst_n         (rst_n),
         .btn           (btn_in[i]),
         .repeat_en     (repeat_en[i]),
         .level         (level[i]),
         .press         (press[i]),
         .release_pulse (release_pulse[i])
      );
   end

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Self-checking bench for btn_debounce_bank: directed latency/repeat scenarios
// plus randomized stimulus against a behavioural per-channel model.
module tb_btn_debounce_bank;

   localparam int N   = 4;
   localparam int SS  = 2;
   localparam int DEB = 4;
   localparam int DLY = 10;
   localparam int RTE = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] btn_in, repeat_en;
   logic [N-1:0] level, press, release_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   btn_debounce_bank #(
      .N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYC(DEB),
      .REPEAT_DELAY(DLY), .REPEAT_RATE(RTE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .repeat_en(repeat_en),
      .level(level), .press(press), .release_pulse(release_pulse)
   );

   // Behavioural model: a button sample is seen SS edges after it is taken;
   // level follows it once DEB consecutive seen samples disagree with level.
   // Repeats count enabled held cycles since the last press event.
   logic [N-1:0] exp_level, exp_press, exp_rel;
   bit           hist[N][$];
   int           run[N], since[N];
   bit           held[N], repeating[N];

   initial begin
      for (int c = 0; c < N; c++) begin
         for (int s = 0; s < SS; s++) hist[c].push_back(1'b0);
      end
   end

   always @(posedge clk) begin
      for (int c = 0; c < N; c++) begin
         bit seen, rose, fell;
         exp_press[c] = 1'b0;
         exp_rel[c]   = 1'b0;
         if (!rst_n) begin
            hist[c].delete();
            for (int s = 0; s < SS; s++) hist[c].push_back(1'b0);
            exp_level[c] = 1'b0;
            run[c] = 0; since[c] = 0; held[c] = 0; repeating[c] = 0;
         end else begin
            seen = hist[c].pop_front();
            hist[c].push_back(btn_in[c]);
            rose = 0; fell = 0;
            if (seen != exp_level[c]) begin
               run[c]++;
               if (run[c] == DEB) begin
                  run[c] = 0;
                  exp_level[c] = seen;
                  rose = seen;
                  fell = !seen;
               end
            end else begin
               run[c] = 0;
            end
            if (rose) begin
               exp_press[c] = 1'b1; held[c] = 1; since[c] = 0; repeating[c] = 0;
            end else if (fell) begin
               exp_rel[c] = 1'b1; held[c] = 0;
            end else if (held[c]) begin
               if (repeat_en[c]) begin
                  since[c]++;
                  if (since[c] == (repeating[c] ? RTE : DLY)) begin
                     exp_press[c] = 1'b1; since[c] = 0; repeating[c] = 1;
                  end
               end else begin
                  since[c] = 0; repeating[c] = 0;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int first = -1;
      rst_n = 1'b0; btn_in = '1; repeat_en = '0;
      for (int i = 0; i < 10; i++) begin
         step();
         n_checks++;
         if ({level, press, release_pulse} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs cyc=%0d got lvl=%b prs=%b rel=%b want all 0", i, level, press, release_pulse);
         end
      end
      rst_n = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         step();
         n_checks++;
         if ({level, press, release_pulse} !== {exp_level, exp_press, exp_rel}) begin
            n_fail++;
            $display("FAIL reset_model n=%0d got %b/%b/%b want %b/%b/%b", n, level, press, release_pulse, exp_level, exp_press, exp_rel);
         end
         if (first < 0 && level === 4'hF) first = n;
      end
      n_checks++;
      if (first !== SS + DEB) begin
         n_fail++;
         $display("FAIL reset_latency got edge %0d want %0d", first, SS + DEB);
      end
      btn_in = '0;
      for (int n = 0; n < 10; n++) step();
   endtask

   task automatic test_clean_press();
      int first = -1, cnt = 0, rfirst = -1, rcnt = 0, pcnt = 0;
      btn_in[0] = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         step();
         n_checks++;
         if ({level, press, release_pulse} !== {exp_level, exp_press, exp_rel}) begin
            n_fail++;
            $display("FAIL clean_model n=%0d got %b/%b/%b want %b/%b/%b", n, level, press, release_pulse, exp_level, exp_press, exp_rel);
         end
         if (press[0]) begin cnt++; if (first < 0) first = n; end
      end
      n_checks++;
      if (first !== 6 || cnt !== 1 || level[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL clean_press got edge=%0d pulses=%0d lvl=%b want edge=6 pulses=1 lvl=1", first, cnt, level[0]);
      end
      btn_in[0] = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         step();
         if (release_pulse[0]) begin rcnt++; if (rfirst < 0) rfirst = n; end
         if (press[0]) pcnt++;
      end
      n_checks++;
      if (rfirst !== 6 || rcnt !== 1 || pcnt !== 0 || level[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL clean_release got edge=%0d rel=%0d prs=%0d lvl=%b want edge=6 rel=1 prs=0 lvl=0", rfirst, rcnt, pcnt, level[0]);
      end
   endtask

   task automatic test_bounce();
      int first = -1;
      for (int k = 0; k < 10; k++) begin
         btn_in[1] = ~btn_in[1];
         for (int j = 0; j < 3; j++) begin
            step();
            n_checks++;
            if ({level[1], press[1], release_pulse[1]} !== 3'b000) begin
               n_fail++;
               $display("FAIL bounce_quiet k=%0d got lvl=%b prs=%b rel=%b want 000", k, level[1], press[1], release_pulse[1]);
            end
         end
      end
      btn_in[1] = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         step();
         n_checks++;
         if ({level, press, release_pulse} !== {exp_level, exp_press, exp_rel}) begin
            n_fail++;
            $display("FAIL bounce_model n=%0d got %b/%b/%b want %b/%b/%b", n, level, press, release_pulse, exp_level, exp_press, exp_rel);
         end
         if (first < 0 && press[1]) first = n;
      end
      n_checks++;
      if (first !== 6) begin
         n_fail++;
         $display("FAIL bounce_settle got edge %0d want 6", first);
      end
      btn_in[1] = 1'b0;
      for (int n = 0; n < 10; n++) step();
   endtask

   task automatic test_auto_repeat();
      int edges[$];
      int want[8] = '{6, 16, 20, 24, 28, 32, 36, 40};
      int cnt = 0;
      repeat_en[2] = 1'b1;
      btn_in[2] = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         step();
         n_checks++;
         if ({level, press, release_pulse} !== {exp_level, exp_press, exp_rel}) begin
            n_fail++;
            $display("FAIL repeat_model n=%0d got %b/%b/%b want %b/%b/%b", n, level, press, release_pulse, exp_level, exp_press, exp_rel);
         end
         if (press[2]) edges.push_back(n);
      end
      n_checks++;
      if (edges.size() != 8) begin
         n_fail++;
         $display("FAIL repeat_count got %0d pulses want 8", edges.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (edges[i] != want[i]) begin
               n_fail++;
               $display("FAIL repeat_edge idx=%0d got %0d want %0d", i, edges[i], want[i]);
            end
         end
      end
      btn_in[2] = 1'b0;
      for (int n = 0; n < 10; n++) step();
      repeat_en[3] = 1'b0;
      btn_in[3] = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (press[3]) cnt++;
      end
      n_checks++;
      if (cnt !== 1) begin
         n_fail++;
         $display("FAIL no_repeat got %0d pulses want 1", cnt);
      end
      btn_in[3] = 1'b0;
      for (int n = 0; n < 10; n++) step();
   endtask

   task automatic test_release_on_expiry();
      int guard = 0, pcnt = 0;
      repeat_en[2] = 1'b1;
      btn_in[2] = 1'b1;
      while (!press[2] && guard < 20) begin step(); guard++; end
      n_checks++;
      if (!press[2]) begin
         n_fail++;
         $display("FAIL expiry_first_press got none within %0d cycles want a press", guard);
      end
      for (int n = 1; n <= 24; n++) begin
         step();
         n_checks++;
         if ({level, press, release_pulse} !== {exp_level, exp_press, exp_rel}) begin
            n_fail++;
            $display("FAIL expiry_model n=%0d got %b/%b/%b want %b/%b/%b", n, level, press, release_pulse, exp_level, exp_press, exp_rel);
         end
         if (press[2]) pcnt++;
         if (n == 12) btn_in[2] = 1'b0;
         if (n == 18) begin
            n_checks++;
            if (press[2] !== 1'b0 || release_pulse[2] !== 1'b1) begin
               n_fail++;
               $display("FAIL expiry_release_wins got prs=%b rel=%b want prs=0 rel=1", press[2], release_pulse[2]);
            end
         end
      end
      n_checks++;
      if (pcnt !== 2) begin
         n_fail++;
         $display("FAIL expiry_repeats got %0d want 2", pcnt);
      end
   endtask

   task automatic test_all_channels();
      int fp[N], fr[N];
      for (int c = 0; c < N; c++) begin fp[c] = -1; fr[c] = -1; end
      repeat_en = 4'b0101;
      btn_in = '1;
      for (int n = 1; n <= 60; n++) begin
         step();
         n_checks++;
         if ({level, press, release_pulse} !== {exp_level, exp_press, exp_rel}) begin
            n_fail++;
            $display("FAIL multi_model n=%0d got %b/%b/%b want %b/%b/%b", n, level, press, release_pulse, exp_level, exp_press, exp_rel);
         end
         for (int c = 0; c < N; c++) begin
            if (fp[c] < 0 && press[c]) fp[c] = n;
            if (fr[c] < 0 && release_pulse[c]) fr[c] = n;
            if (n == 10 + 7 * c) btn_in[c] = 1'b0;
         end
      end
      for (int c = 0; c < N; c++) begin
         n_checks++;
         if (fp[c] != 6 || fr[c] != 16 + 7 * c) begin
            n_fail++;
            $display("FAIL multi_chan%0d got press=%0d rel=%0d want press=6 rel=%0d", c, fp[c], fr[c], 16 + 7 * c);
         end
      end
   endtask

   task automatic test_mid_reset();
      repeat_en = '1;
      btn_in = '1;
      for (int n = 1; n <= 25; n++) begin
         step();
         n_checks++;
         if ({level, press, release_pulse} !== {exp_level, exp_press, exp_rel}) begin
            n_fail++;
            $display("FAIL midrst_model n=%0d got %b/%b/%b want %b/%b/%b", n, level, press, release_pulse, exp_level, exp_press, exp_rel);
         end
      end
      rst_n = 1'b0;
      for (int n = 0; n < 3; n++) begin
         step();
         n_checks++;
         if ({level, press, release_pulse} !== 12'h000) begin
            n_fail++;
            $display("FAIL midrst_clear n=%0d got %b/%b/%b want all 0", n, level, press, release_pulse);
         end
      end
      rst_n = 1'b1;
      btn_in = '0;
      for (int n = 0; n < 15; n++) begin
         step();
         n_checks++;
         if ({level, press, release_pulse} !== 12'h000) begin
            n_fail++;
            $display("FAIL midrst_quiet n=%0d got %b/%b/%b want all 0", n, level, press, release_pulse);
         end
      end
   endtask

   task automatic test_random();
      int hold[N];
      for (int c = 0; c < N; c++) hold[c] = 0;
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < N; c++) begin
            if (hold[c] == 0) begin
               btn_in[c] = 1'($urandom_range(0, 1));
               hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 6));
            end else begin
               hold[c]--;
            end
            if ($urandom_range(0, 59) == 0) repeat_en[c] = ~repeat_en[c];
         end
         step();
         n_checks++;
         if ({level, press, release_pulse} !== {exp_level, exp_press, exp_rel}) begin
            n_fail++;
            $display("FAIL random_model n=%0d got %b/%b/%b want %b/%b/%b", n, level, press, release_pulse, exp_level, exp_press, exp_rel);
         end
         n_checks++;
         if ((press & release_pulse) !== 4'h0) begin
            n_fail++;
            $display("FAIL random_exclusive n=%0d got prs&rel=%b want 0000", n, press & release_pulse);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; btn_in = '0; repeat_en = '0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_auto_repeat();
      test_release_on_expiry();
      test_all_channels();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/btn_debounce_bank.md
# btn_debounce_bank

Parametrised multi-channel pushbutton conditioner that replaces the per-button debouncer instances in the VGA game top level. Each channel synchronises a raw asynchronous button, debounces it with a configurable stability window, and produces a clean level plus single-cycle press/release pulses. An optional per-channel auto-repeat (typematic) mode re-issues press pulses while a button is held, so movement keys behave like a keyboard. The block sits between the board button pins and `vgaDraw`, in the 25 MHz clock domain.

## Interface
- `N_CH`, 4: number of independent button channels.
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `DEBOUNCE_CYC`, 50000: consecutive stable cycles required to accept a change (2 ms at 25 MHz, ≥1).
- `REPEAT_DELAY`, 12500000: cycles from first press to first repeat (0.5 s, ≥1).
- `REPEAT_RATE`, 2500000: cycles between subsequent repeats (0.1 s, ≥1).

- `clk`  in  1  25 MHz system clock; sole clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `btn_in`  in  N_CH  raw asynchronous button inputs, active high.
- `repeat_en`  in  N_CH  per-channel auto-repeat enable.
- `level`  out  N_CH  debounced button state.
- `press`  out  N_CH  one-cycle pulse on accepted press and on each repeat.
- `release`  out  N_CH  one-cycle pulse on accepted release.

## Operation
- Per channel: `SYNC_STAGES` flop chain → debounce counter → repeat FSM. Channels are fully independent.
- Debounce: counter increments each cycle that synchronised input ≠ `level`; cleared on any cycle they match. On the cycle the counter holds `DEBOUNCE_CYC-1` and mismatch persists, `level` toggles and the counter clears. Counter width `$clog2(DEBOUNCE_CYC+1)`; never wraps.
- Repeat FSM states: IDLE, HELD_DELAY, HELD_REPEAT. Timer width `$clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)`.
  - IDLE → HELD_DELAY on `level` rise; `press` pulses, timer clears.
  - HELD_DELAY: if `repeat_en` high, timer counts; at `REPEAT_DELAY-1` → HELD_REPEAT, `press` pulses, timer clears. If `repeat_en` low, timer holds at 0.
  - HELD_REPEAT: timer counts; at `REPEAT_RATE-1` `press` pulses, timer clears. `repeat_en` low → HELD_DELAY, timer cleared, no pulse.
  - Any HELD state → IDLE on `level` fall; `release` pulses; no `press` that cycle even if timer expires simultaneously (release wins).
- `press` and `release` never assert together on one channel.
- Reset: all sync flops, counters, timers cleared; FSM IDLE; `level`, `press`, `release` all 0. A button held through reset deassertion is seen as a new press after the normal debounce latency.

## Timing
- All outputs registered.
- Latency: input stable from edge 0 → `level` and first `press` change at edge `SYNC_STAGES + DEBOUNCE_CYC`; same latency for release.
- Any glitch shorter than `DEBOUNCE_CYC` cycles (post-sync) produces no output activity.
- First repeat: `REPEAT_DELAY` cycles after initial `press`; subsequent repeats every `REPEAT_RATE` cycles.
- `repeat_en` is used unsynchronised (assumed from the `clk` domain); changes take effect on the next edge.

## Structure
- Shared package `btn_pkg`: FSM state enum (IDLE/HELD_DELAY/HELD_REPEAT), default cycle constants for 25 MHz.
- Sub-module `btn_chan`: one channel (sync, debounce counter, repeat FSM), instantiated `N_CH` times via generate. Top level is wiring plus parameter legality checks.

## Test plan
- Reset: `btn_in`=4'hF, `rst_n` low 10 cycles → all outputs 0 throughout; after release `level`=4'hF at edge SYNC_STAGES+DEBOUNCE_CYC.
- Clean press, DEBOUNCE_CYC=4, SYNC_STAGES=2: `btn_in[0]` rises at edge 0 → `level[0]` and single `press[0]` pulse at edge 6; drop → `release[0]` at +6.
- Bounce: toggle `btn_in[1]` every 3 cycles for 30 cycles (DEBOUNCE_CYC=4) → no output change; then hold high → press 6 cycles after last edge.
- Auto-repeat, REPEAT_DELAY=10, REPEAT_RATE=4, `repeat_en`=1, hold → `press` at t, t+10, t+14, t+18…; with `repeat_en`=0 → only press at t.
- Release coincident with repeat expiry → `release` only, no `press`, FSM IDLE.
- All four channels pressed on the same edge with staggered releases → independent, correctly timed pulses per channel; `rst_n` low mid-repeat clears everything immediately.
